// File: rtl/coin_cond_pkg.sv
// Shared types and constants for the coin input conditioner.
// Contents: per-channel state enum and channel index constants.
package coin_cond_pkg;

    typedef enum logic [2:0] {
        WAIT_LO,
        IDLE,
        DEB_HI,
        HELD,
        JAM
    } ch_state_e;

    localparam int unsigned N_CH = 2;
    localparam int unsigned CH_X = 0;
    localparam int unsigned CH_Y = 1;

endpackage

// File: rtl/coin_input_conditioner_if.sv
// Coin-slot bus between the raw contacts, the conditioner and the vending FSM.
// Signals:
//   coin_x_raw, coin_y_raw : raw asynchronous, bouncy slot contacts
//   coinx, coiny           : clean one-cycle coin pulses
//   coin_jam[1:0]          : bit0 = X jammed, bit1 = Y jammed
// Modports: master drives the raw contacts and observes the outputs,
// slave is the conditioner.
interface coin_input_conditioner_if;

    logic       coin_x_raw;
    logic       coin_y_raw;
    logic       coinx;
    logic       coiny;
    logic [1:0] coin_jam;

    modport master (
        output coin_x_raw,
        output coin_y_raw,
        input  coinx,
        input  coiny,
        input  coin_jam
    );

    modport slave (
        input  coin_x_raw,
        input  coin_y_raw,
        output coinx,
        output coiny,
        output coin_jam
    );

endinterface

// File: rtl/coin_input_conditioner_debounce_ch.sv
// One coin channel: input synchronizer, debounce / stuck-contact FSM and counter.
// Optional jam detection is built when COIN_JAM_DETECT_EN is defined.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   raw_i     : raw asynchronous contact
//   accept_c  : one-cycle accept event, decoded from the current state
//   jam_o     : channel currently jammed (state decode, 0 without jam detection)
module coin_debounce_ch
    import coin_cond_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned JAM_CYCLES      = 4096,
    parameter int unsigned CNT_W           = $clog2(JAM_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic accept_c,
    output logic jam_o
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef COIN_JAM_DETECT_EN
    localparam logic [CNT_W-1:0] JAM_LAST = CNT_W'(JAM_CYCLES - 1);
`endif

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    ch_state_e              state_q;
    logic [CNT_W-1:0]       cnt_q;

    // Metastability chain; s is the last stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Channel FSM; counter clears on every state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_LO;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                WAIT_LO: begin
                    // A contact already high here is never credited.
                    if (s) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                IDLE: begin
                    if (s) begin
                        state_q <= DEB_HI;
                        cnt_q   <= CNT_W'(1);   // entry sample counts
                    end
                end
                DEB_HI: begin
                    if (!s) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!s) begin
                        state_q <= WAIT_LO;
                        cnt_q   <= '0;
`ifdef COIN_JAM_DETECT_EN
                    end else if (cnt_q == JAM_LAST) begin
                        state_q <= JAM;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
`endif
                    end
                end
`ifdef COIN_JAM_DETECT_EN
                JAM: begin
                    if (s) begin
                        cnt_q <= '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
`endif
                default: begin
                    state_q <= WAIT_LO;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Accept on the final stable high sample, i.e. the DEB_HI -> HELD step.
    assign accept_c = (state_q == DEB_HI) && s && (cnt_q == DEB_LAST);

`ifdef COIN_JAM_DETECT_EN
    assign jam_o = (state_q == JAM);
`else
    assign jam_o = 1'b0;
`endif

endmodule

// File: rtl/coin_input_conditioner.sv
// Coin input conditioner: two debounced coin channels plus an output arbiter
// that emits at most one coin pulse per cycle without losing any coin.
// Jam detection is built when COIN_JAM_DETECT_EN is defined; otherwise
// coin_jam stays 2'b00.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : coin_input_conditioner_if.slave (raw contacts in,
//              coinx / coiny / coin_jam out, all outputs registered)
module coin_input_conditioner
    import coin_cond_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned JAM_CYCLES      = 4096,
    parameter int unsigned CNT_W           = $clog2(JAM_CYCLES + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    coin_input_conditioner_if.slave    bus
);

    logic [N_CH-1:0] raw;
    logic [N_CH-1:0] accept_c;
    logic [N_CH-1:0] jam;

    logic       coinx_q, coinx_d;
    logic       coiny_q, coiny_d;
    logic       pend_x_q, pend_x_d;
    logic       pend_y_q, pend_y_d;
    logic [1:0] coin_jam_q;

    assign raw[CH_X] = bus.coin_x_raw;
    assign raw[CH_Y] = bus.coin_y_raw;

    coin_debounce_ch #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .JAM_CYCLES      (JAM_CYCLES),
        .CNT_W           (CNT_W)
    ) u_ch_x (
        .clk      (clk),
        .rst      (rst),
        .raw_i    (raw[CH_X]),
        .accept_c (accept_c[CH_X]),
        .jam_o    (jam[CH_X])
    );

    coin_debounce_ch #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .JAM_CYCLES      (JAM_CYCLES),
        .CNT_W           (CNT_W)
    ) u_ch_y (
        .clk      (clk),
        .rst      (rst),
        .raw_i    (raw[CH_Y]),
        .accept_c (accept_c[CH_Y]),
        .jam_o    (jam[CH_Y])
    );

    // Grant order: pending Y, pending X, fresh X, fresh Y; losers go pending.
    // Pending flags are one deep: a channel cannot re-accept within 2 cycles.
    always_comb begin
        coinx_d = 1'b0;
        coiny_d = 1'b0;
        if (pend_y_q) begin
            coiny_d = 1'b1;
        end else if (pend_x_q) begin
            coinx_d = 1'b1;
        end else if (accept_c[CH_X]) begin
            coinx_d = 1'b1;
        end else if (accept_c[CH_Y]) begin
            coiny_d = 1'b1;
        end
        pend_x_d = (pend_x_q | accept_c[CH_X]) & ~coinx_d;
        pend_y_d = (pend_y_q | accept_c[CH_Y]) & ~coiny_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            coinx_q    <= 1'b0;
            coiny_q    <= 1'b0;
            pend_x_q   <= 1'b0;
            pend_y_q   <= 1'b0;
            coin_jam_q <= 2'b00;
        end else begin
            coinx_q    <= coinx_d;
            coiny_q    <= coiny_d;
            pend_x_q   <= pend_x_d;
            pend_y_q   <= pend_y_d;
            coin_jam_q <= {jam[CH_Y], jam[CH_X]};
        end
    end

    assign bus.coinx    = coinx_q;
    assign bus.coiny    = coiny_q;
    assign bus.coin_jam = coin_jam_q;

endmodule

// File: doc/coin_input_conditioner.md
Name: coin_input_conditioner

Overview:
- Upstream stage of the vending machine FSM. Conditions two raw, asynchronous, bouncy coin-slot contacts into clean single-cycle `coinx`/`coiny` pulses.
- Per channel: synchronizer, debounce, and stuck-contact (jam) detection.
- Output arbiter guarantees at most one coin pulse per cycle, so the downstream FSM never sees coincident coins.

Parameters:
- SYNC_STAGES, 2, flops in each input synchronizer chain (must be ≥2).
- DEBOUNCE_CYCLES, 16, consecutive stable samples needed to accept a level (must be ≥2).
- JAM_CYCLES, 4096, consecutive high samples in HELD before declaring a jam (must be > DEBOUNCE_CYCLES).
- CNT_W, $clog2(JAM_CYCLES+1), width of the per-channel counter.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- coin_x_raw  in  1  raw slot-X contact, asynchronous, bouncy.
- coin_y_raw  in  1  raw slot-Y contact, asynchronous, bouncy.
- coinx  out  1  registered one-cycle pulse per accepted X coin.
- coiny  out  1  registered one-cycle pulse per accepted Y coin.
- coin_jam  out  2  registered; bit0 = X jammed, bit1 = Y jammed.

Behaviour:
- Reset values:
  - sync flops = 0
  - channel state = WAIT_LO
  - counters = 0
  - pending flags = 0
  - coinx = 0, coiny = 0, coin_jam = 2'b00
- Reset applied mid-operation aborts everything; any queued pending coin is discarded.
- Per-channel FSM on synchronized input s; cnt clears on every state change:
  - WAIT_LO: s=0 counts; cnt reaching DEBOUNCE_CYCLES → IDLE. s=1 → HELD, no pulse.
    - Consequence: a contact held high through reset is never credited.
  - IDLE: s=1 → DEB_HI.
  - DEB_HI: s=1 counts; on the DEBOUNCE_CYCLES-th consecutive high sample (including the entry sample) → HELD and raise accept event. s=0 → IDLE.
  - HELD: s=0 → WAIT_LO. s=1 counts; cnt reaching JAM_CYCLES → JAM.
  - JAM: coin_jam bit high. s=0 counts; DEBOUNCE_CYCLES consecutive lows → IDLE and clear the jam bit. s=1 clears cnt.
- Latency:
  - Raw input first sampled high at edge N, then stable.
  - Synchronized s is high at edge N+SYNC_STAGES−1.
  - Accept event at edge N+SYNC_STAGES+DEBOUNCE_CYCLES−2.
  - coinx is high for the cycle after that edge.
  - With defaults, 17 edges from first sample to coinx rising.
- Arbiter, per cycle:
  - Priority 1: pending_y, then pending_x.
  - Priority 2: fresh X events before fresh Y events.
  - Exactly one pulse per cycle; every loser sets its channel's pending flag.
  - Pending flags are one deep. DEBOUNCE_CYCLES≥2 guarantees no second event can arrive while a flag is set.
  - Simultaneous X and Y accept: coinx pulses in cycle k, coiny in cycle k+1.
- No coin is ever lost or duplicated. Exactly one pulse per IDLE→DEB_HI→HELD traversal.
- Bounce shorter than DEBOUNCE_CYCLES samples produces no pulse.

Optional Feature:
- COIN_JAM_DETECT_EN:
  - Defined: JAM state, jam counting and coin_jam behave as above.
  - Undefined: HELD never times out, JAM state is absent, coin_jam is tied to 2'b00, and JAM_CYCLES is ignored.
  - Pulse behaviour is identical either way.

Decomposition:
- Package coin_cond_pkg: channel state enum (WAIT_LO, IDLE, DEB_HI, HELD, JAM) and index constants CH_X=0, CH_Y=1.
- Sub-module coin_debounce_ch: synchronizer + per-channel FSM + counter. Outputs are accept (1-cycle event) and jam.
  - Instantiated twice.
  - Arbiter and output registers live in the top.

Test Plan:
- Reset, then coin_x_raw held high 40 cycles, then low → exactly one coinx pulse, 17 edges after first high sample; coiny=0 throughout.
- coin_y_raw bounces 1/0 every 3 cycles for 30 cycles, then is held high 20 cycles → no pulse during the bounce; exactly one coiny pulse after the stable run.
- Both raw inputs rise on the same edge and are held 30 cycles → coinx in cycle k, coiny in cycle k+1, never both high together.
- coin_x_raw held high through reset deassertion for 100 cycles, then low 20 cycles, then high 20 cycles → no pulse for the first run; one coinx pulse for the second.
- With COIN_JAM_DETECT_EN defined, JAM_CYCLES=64: coin_x_raw held high 200 cycles → one coinx pulse and coin_jam[0]=1. Input then low 16 cycles → coin_jam[0]=0. Next clean coin is accepted normally.
- Rst asserted one cycle after a simultaneous X+Y accept (coiny still pending) → no coiny pulse; all outputs 0 on the next cycle.
